s117_spi_master: RTL and testbench

SPI initiator that drives the S117 display controller's serial register interface from the host side of the design. A single `start` request runs a complete 2-byte framed transaction on `CS`/`SCK`/`MOSI`/`MISO`. Byte 0 is the control word (command and register address). Byte 1 is write data, or the register value returned on `MISO` for a read. The block sits between a local command source (sequencer or CPU bridge) and the S117 pins.

---
 rtl/s117_spi_master.sv | 161 ++++++++++++++++
 tb/tb_s117_spi_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s117_spi_master.sv
// SPI mode-0 initiator for the S117 display controller: one start request runs a
// two-byte CS frame (control word, then write data or read-back), MSB first.
module s117_spi_master #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 8,
    parameter int BYTE_GAP = 16,
    parameter int CS_HOLD  = 8
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       CS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] fsm_state
);

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (BYTE_GAP > CS_HOLD) ? BYTE_GAP : CS_HOLD;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] LD_DIV   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(BYTE_GAP - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT0 = 3'd2,
        GAP    = 3'd3,
        SHIFT1 = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic          byte_sel;
    logic          rw_q;
    logic [7:0]    ctrl_q;
    logic [7:0]    data_q;
    logic [7:0]    rx_sh;
    logic [7:0]    cur_byte;
    logic          miso_meta;
    logic          miso_s;

    assign fsm_state = state;
    assign cur_byte  = byte_sel ? data_q : ctrl_q;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= MISO;
            miso_s    <= miso_meta;
        end
    end

    // Handshake: start is sampled only while busy=0 (state IDLE); busy rises the
    // cycle after acceptance and drops in the single done cycle, so a held start
    // launches the next frame on the edge that closes the done cycle.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            CS       <= 1'b1;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            byte_sel <= 1'b0;
            rw_q     <= 1'b0;
            ctrl_q   <= 8'h00;
            data_q   <= 8'h00;
            rx_sh    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rw_q     <= rw;
                        ctrl_q   <= {rw, 3'b000, addr};
                        data_q   <= rw ? wdata : 8'h00;
                        CS       <= 1'b0;
                        busy     <= 1'b1;
                        MOSI     <= rw;
                        cnt      <= LD_SETUP;
                        byte_sel <= 1'b0;
                        state    <= SETUP;
                    end
                end
                // SETUP and GAP stand in for the low phase of each byte's first bit.
                SETUP, GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        SCK     <= 1'b1;
                        cnt     <= LD_DIV;
                        bit_cnt <= 3'd7;
                        state   <= byte_sel ? SHIFT1 : SHIFT0;
                    end
                end
                SHIFT0, SHIFT1: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!SCK) begin
                        SCK <= 1'b1;
                        cnt <= LD_DIV;
                    end else begin
                        // Last cycle of the high phase: sample MISO, then fall and advance.
                        SCK <= 1'b0;
                        if (byte_sel) begin
                            rx_sh <= {rx_sh[6:0], miso_s};
                        end
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            MOSI    <= cur_byte[bit_cnt - 3'd1];
                            cnt     <= LD_DIV;
                        end else if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            MOSI     <= data_q[7];
                            cnt      <= LD_GAP;
                            state    <= GAP;
                        end else begin
                            MOSI  <= 1'b0;
                            cnt   <= LD_HOLD;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        CS    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!rw_q) begin
                            rdata <= rx_sh;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s117_spi_master.sv
// Bench for s117_spi_master: two instances (default timing and all-4 timing), each
// with an SPI slave model that decodes MOSI, returns a byte on MISO and checks SCK/MOSI rules.
module tb_s117_spi_master;

    logic       mclk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso_byte [2];

    wire [1:0]  cs_w, sck_w, mosi_w, busy_w, done_w;
    wire [7:0]  rdata_w [2];
    wire [2:0]  fsm_w [2];
    wire [15:0] rx_w [2];
    wire [31:0] rises_w [2];
    wire [31:0] frames_w [2];
    wire [31:0] hibad_w [2];
    wire [31:0] viol_w [2];

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int DIV = (gi == 0) ? 8 : 4;
        logic       cs, sck, mosi, busy, done;
        logic [7:0] rdata;
        logic [2:0] fsm;
        logic       miso = 1'b1;
        int         rises = 0;
        int         frames = 0;
        int         hi_len = 0;
        int         hi_bad = 0;
        int         viol = 0;
        logic [15:0] rx = '0;
        logic       p_cs = 1'b1;
        logic       p_sck = 1'b0;
        logic       p_mosi = 1'b0;

        s117_spi_master #(
            .CLK_DIV (DIV),
            .CS_SETUP((gi == 0) ? 8 : 4),
            .BYTE_GAP((gi == 0) ? 16 : 4),
            .CS_HOLD ((gi == 0) ? 8 : 4)
        ) dut (
            .mclk     (mclk),
            .rst      (rst),
            .start    (start[gi]),
            .rw       (rw),
            .addr     (addr),
            .wdata    (wdata),
            .busy     (busy),
            .done     (done),
            .rdata    (rdata),
            .CS       (cs),
            .SCK      (sck),
            .MOSI     (mosi),
            .MISO     (miso),
            .fsm_state(fsm)
        );

        // Slave model: shift MOSI at SCK rise, present the next MISO bit at SCK fall.
        always @(negedge mclk) begin
            if (p_cs && !cs) begin
                rises = 0;
                rx = '0;
                miso = 1'b1;
                frames++;
            end
            if (!cs) begin
                if (sck && !p_sck) begin
                    if (mosi != p_mosi) viol++;
                    rx = {rx[14:0], mosi};
                    rises++;
                    hi_len = 1;
                end else if (sck && p_sck) begin
                    if (mosi != p_mosi) viol++;
                    hi_len++;
                end else if (!sck && p_sck) begin
                    if (hi_len != DIV) hi_bad++;
                    if (rises >= 8 && rises <= 15) miso = miso_byte[gi][15 - rises];
                end
            end
            p_cs = cs;
            p_sck = sck;
            p_mosi = mosi;
        end

        assign cs_w[gi]     = cs;
        assign sck_w[gi]    = sck;
        assign mosi_w[gi]   = mosi;
        assign busy_w[gi]   = busy;
        assign done_w[gi]   = done;
        assign rdata_w[gi]  = rdata;
        assign fsm_w[gi]    = fsm;
        assign rx_w[gi]     = rx;
        assign rises_w[gi]  = rises;
        assign frames_w[gi] = frames;
        assign hibad_w[gi]  = hi_bad;
        assign viol_w[gi]   = viol;
    end

    typedef struct {
        int         inst;
        logic       rw;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] mbyte;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [6];

    function automatic int setup_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? (1 + 8 + 15 * 8 + 16 + 15 * 8 + 8) : (1 + 4 + 60 + 4 + 60 + 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called just after the acceptance edge t0; k counts cycles so that k=1 is t0+1.
    task automatic wait_frame(input int i, input int k0, output int n);
        n = 0;
        for (int k = k0; k <= 3000; k++) begin
            @(negedge mclk);
            if (k == 1) begin
                chk("cs_low_t1", cs_w[i], 1'b0);
                chk("busy_t1", busy_w[i], 1'b1);
            end
            if (k == setup_of(i)) chk("sck_before_rise", sck_w[i], 1'b0);
            if (k == setup_of(i) + 1) chk("sck_first_rise", sck_w[i], 1'b1);
            if (done_w[i]) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge mclk);
        rw = v.rw;
        addr = v.addr;
        wdata = v.wdata;
        miso_byte[v.inst] = v.mbyte;
        start[v.inst] = 1'b1;
        @(posedge mclk);
        #1;
        start[v.inst] = 1'b0;
        rw = ~v.rw;
        addr = ~v.addr;
        wdata = ~v.wdata;
        wait_frame(v.inst, 1, n);
        chk("latency", n, lat_of(v.inst));
        chk("done_cs_high", cs_w[v.inst], 1'b1);
        chk("done_busy_low", busy_w[v.inst], 1'b0);
        chk("mosi_bytes", rx_w[v.inst], {v.b0, v.b1});
        chk("sck_rises", rises_w[v.inst], 32'd16);
        chk("rdata", rdata_w[v.inst], v.rdata);
        @(negedge mclk);
        chk("done_one_cycle", done_w[v.inst], 1'b0);
        chk("fsm_idle", fsm_w[v.inst], 3'd0);
    endtask

    initial begin
        int n;
        int f0;

        vecs[0] = '{0, 1'b1, 4'h1, 8'h10, 8'h5A, 8'h81, 8'h10, 8'h00};
        vecs[1] = '{0, 1'b0, 4'h4, 8'h77, 8'hA5, 8'h04, 8'h00, 8'hA5};
        vecs[2] = '{0, 1'b1, 4'hF, 8'hFF, 8'h00, 8'h8F, 8'hFF, 8'hA5};
        vecs[3] = '{1, 1'b0, 4'hA, 8'h12, 8'h3C, 8'h0A, 8'h00, 8'h3C};
        vecs[4] = '{1, 1'b1, 4'h3, 8'h6B, 8'hFF, 8'h83, 8'h6B, 8'h3C};
        vecs[5] = '{0, 1'b0, 4'h0, 8'hEE, 8'h81, 8'h00, 8'h00, 8'h81};

        // Clock/reset
        rst = 1'b1;
        start = 2'b00;
        rw = 1'b0;
        addr = 4'h0;
        wdata = 8'h00;
        miso_byte[0] = 8'h00;
        miso_byte[1] = 8'h00;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", cs_w[i], 1'b1);
            chk("rst_sck", sck_w[i], 1'b0);
            chk("rst_mosi", mosi_w[i], 1'b0);
            chk("rst_busy", busy_w[i], 1'b0);
            chk("rst_done", done_w[i], 1'b0);
            chk("rst_rdata", rdata_w[i], 8'h00);
            chk("rst_fsm", fsm_w[i], 3'd0);
        end

        // Reset in the 4th bit of byte 1 of a read
        @(negedge mclk);
        rw = 1'b0;
        addr = 4'h7;
        miso_byte[0] = 8'hFF;
        start[0] = 1'b1;
        @(posedge mclk);
        #1;
        start[0] = 1'b0;
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge mclk);
            if (rises_w[0] == 12) begin
                n = k;
                break;
            end
        end
        chk("reached_byte1_bit4", n != 0, 1'b1);
        repeat (3) @(negedge mclk);
        rst = 1'b1;
        #1;
        chk("arst_cs", cs_w[0], 1'b1);
        chk("arst_sck", sck_w[0], 1'b0);
        chk("arst_mosi", mosi_w[0], 1'b0);
        chk("arst_busy", busy_w[0], 1'b0);
        chk("arst_rdata", rdata_w[0], 8'h00);
        @(negedge mclk);
        rst = 1'b0;
        repeat (20) @(negedge mclk);
        chk("no_resume_cs", cs_w[0], 1'b1);
        chk("no_resume_busy", busy_w[0], 1'b0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // start pulsed repeatedly while busy: only one frame
        f0 = frames_w[0];
        @(negedge mclk);
        rw = 1'b1;
        addr = 4'h2;
        wdata = 8'h5C;
        start[0] = 1'b1;
        @(posedge mclk);
        #1;
        start[0] = 1'b0;
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge mclk);
            start[0] = (k < 250) && (k % 5 == 0);
            if (done_w[0]) begin
                n = k;
                break;
            end
        end
        start[0] = 1'b0;
        chk("pulse_latency", n, lat_of(0));
        chk("pulse_bytes", rx_w[0], 16'h825C);
        repeat (40) @(negedge mclk);
        chk("pulse_one_frame", frames_w[0] - f0, 32'd1);
        chk("pulse_idle", busy_w[0], 1'b0);
        chk("pulse_rdata_kept", rdata_w[0], 8'h81);

        // start held high: back-to-back frames, fields latched per frame
        @(negedge mclk);
        rw = 1'b1;
        addr = 4'h2;
        wdata = 8'hC3;
        miso_byte[1] = 8'h96;
        start[1] = 1'b1;
        @(posedge mclk);
        #1;
        rw = 1'b0;
        addr = 4'h5;
        wdata = 8'hEE;
        wait_frame(1, 1, n);
        chk("b2b_latency1", n, lat_of(1));
        chk("b2b_done_cs_high", cs_w[1], 1'b1);
        chk("b2b_bytes1", rx_w[1], 16'h82C3);
        chk("b2b_rdata1", rdata_w[1], 8'h3C);
        @(negedge mclk);
        chk("b2b_cs_relow", cs_w[1], 1'b0);
        chk("b2b_busy_again", busy_w[1], 1'b1);
        start[1] = 1'b0;
        wait_frame(1, 2, n);
        chk("b2b_latency2", n, lat_of(1));
        chk("b2b_bytes2", rx_w[1], 16'h0500);
        chk("b2b_rdata2", rdata_w[1], 8'h96);
        @(negedge mclk);

        for (int i = 0; i < 2; i++) begin
            chk("mosi_stable_sck_high", viol_w[i], 32'd0);
            chk("sck_high_len", hibad_w[i], 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
